// File: rtl/fft_power_rx.sv
// fft_power_rx: turns STFFT bins into |X|^2, captures the non-redundant half spectrum of each
// frame into one of two banks, and replays completed frames as a valid/ready stream.
module fft_power_rx #(
    parameter int IW       = 18,
    parameter int FFT_SIZE = 256,
    parameter int LGNB     = $clog2(FFT_SIZE / 2)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_ce,
    input  logic [2*IW-1:0]   i_fft_result,
    input  logic              i_fft_sync,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [2*IW-1:0]   o_power,
    output logic [LGNB-1:0]   o_bin,
    output logic              o_last,
    output logic              o_overflow,
    input  logic              i_clr_overflow
);
    localparam int PW = 2 * IW;
    localparam int NBINS = FFT_SIZE / 2;
    localparam logic [LGNB-1:0] LastBin = LGNB'(NBINS - 1);

    typedef enum logic {WrWaitSync, WrCapture} wr_state_e;
    typedef enum logic {RdIdle, RdStream} rd_state_e;
    typedef enum logic [1:0] {BankEmpty, BankWriting, BankFull} bank_st_e;

    // Write side
    wr_state_e            wr_state_q, wr_state_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [LGNB-1:0]      wr_cnt_q, wr_cnt_d;
    bank_st_e [1:0]       bank_st_q, bank_st_d;
    logic                 in_wr, in_last, take, ov_set;
    logic [LGNB-1:0]      in_bin;
    logic [1:0]           bank_free;
    // Power pipeline
    logic signed [IW-1:0] in_re, in_im;
    logic [PW-1:0]        re_sq, im_sq;
    logic                 s1_vld_q, s1_bank_q, s1_last_q;
    logic [LGNB-1:0]      s1_bin_q;
    logic [PW-1:0]        s1_re2_q, s1_im2_q;
    logic                 s2_vld_q, s2_bank_q, s2_last_q;
    logic [LGNB-1:0]      s2_bin_q;
    logic [PW-1:0]        s2_pwr_q;
    logic [PW-1:0]        mem [2*NBINS];
    // Full-bank order queue (oldest at index 0)
    logic [1:0]           fq_q, fq_d;
    logic [1:0]           fq_cnt_q, fq_cnt_d;
    logic                 fq_pop, fq_push;
    // Read side and 2-entry output buffer that doubles as the registered RAM read
    rd_state_e            rd_state_q, rd_state_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [LGNB-1:0]      rd_bin_q, rd_bin_d;
    logic                 rd_issue, issue_bank, issue_last, space, pop_out, rel_vld, rel_bank;
    logic [LGNB-1:0]      issue_bin;
    logic [1:0][PW-1:0]   fo_pwr_q, fo_pwr_d;
    logic [1:0][LGNB-1:0] fo_bin_q, fo_bin_d;
    logic [1:0]           fo_last_q, fo_last_d, fo_bank_q, fo_bank_d;
    logic                 fo_head_q, fo_head_d, fo_wr_idx;
    logic [1:0]           fo_cnt_q, fo_cnt_d;
    logic                 ov_q, ov_d;

    assign in_re = i_fft_result[PW-1:IW];
    assign in_im = i_fft_result[IW-1:0];
    // Signed squares are non-negative, so their sum fits PW unsigned bits exactly.
    assign re_sq = PW'(in_re) * PW'(in_re);
    assign im_sq = PW'(in_im) * PW'(in_im);

    assign o_valid    = (fo_cnt_q != 2'd0);
    assign o_power    = fo_pwr_q[fo_head_q];
    assign o_bin      = fo_bin_q[fo_head_q];
    assign o_last     = fo_last_q[fo_head_q];
    assign o_overflow = ov_q;
    assign pop_out    = o_valid && i_ready;
    assign rel_vld    = pop_out && o_last;
    assign rel_bank   = fo_bank_q[fo_head_q];
    assign fq_push    = s2_vld_q && s2_last_q;
    assign space      = (fo_cnt_q != 2'd2) || pop_out;

    // A bank released by the reader this cycle is already free for a new frame.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_free[b] = (bank_st_q[b] == BankEmpty) || (rel_vld && (rel_bank == 1'(b)));
        end
    end

    // Write FSM: frame alignment, bank selection, bin numbering, drop detection
    always_comb begin
        wr_state_d = wr_state_q;
        wr_bank_d  = wr_bank_q;
        wr_cnt_d   = wr_cnt_q;
        in_wr      = 1'b0;
        in_bin     = wr_cnt_q;
        in_last    = 1'b0;
        take       = 1'b0;
        ov_set     = 1'b0;
        unique case (wr_state_q)
            WrWaitSync: begin
                if (i_ce && i_fft_sync) begin
                    if (bank_free[0]) begin
                        take = 1'b1;
                        wr_bank_d = 1'b0;
                    end else if (bank_free[1]) begin
                        take = 1'b1;
                        wr_bank_d = 1'b1;
                    end else begin
                        ov_set = 1'b1;
                    end
                    if (take) begin
                        in_wr      = 1'b1;
                        in_bin     = '0;
                        wr_cnt_d   = LGNB'(1);
                        wr_state_d = WrCapture;
                    end
                end
            end
            WrCapture: begin
                if (i_ce) begin
                    in_wr = 1'b1;
                    if (i_fft_sync) begin
                        // Restart in the same bank; stale bins get overwritten in order.
                        in_bin   = '0;
                        wr_cnt_d = LGNB'(1);
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                        if (wr_cnt_q == LastBin) begin
                            in_last    = 1'b1;
                            wr_state_d = WrWaitSync;
                        end
                    end
                end
            end
            default: wr_state_d = WrWaitSync;
        endcase
    end

    // Bank ownership: writer claims, last write marks full, last handshake frees
    always_comb begin
        bank_st_d = bank_st_q;
        if (rel_vld) bank_st_d[rel_bank] = BankEmpty;
        if (fq_push) bank_st_d[s2_bank_q] = BankFull;
        if (take) bank_st_d[wr_bank_d] = BankWriting;
    end

    // Full-bank queue keeps frames in completion order
    always_comb begin
        fq_d     = fq_q;
        fq_cnt_d = fq_cnt_q;
        if (fq_pop) begin
            fq_d[0]  = fq_q[1];
            fq_cnt_d = fq_cnt_q - 2'd1;
        end
        if (fq_push) begin
            fq_d[fq_cnt_d[0]] = s2_bank_q;
            fq_cnt_d          = fq_cnt_d + 2'd1;
        end
    end

    // Read FSM: issues one RAM read per cycle whenever the output buffer has room
    always_comb begin
        rd_state_d = rd_state_q;
        rd_bank_d  = rd_bank_q;
        rd_bin_d   = rd_bin_q;
        rd_issue   = 1'b0;
        fq_pop     = 1'b0;
        issue_bank = rd_bank_q;
        issue_bin  = rd_bin_q;
        unique case (rd_state_q)
            RdIdle: begin
                if ((fq_cnt_q != 2'd0) && space) begin
                    fq_pop     = 1'b1;
                    rd_issue   = 1'b1;
                    issue_bank = fq_q[0];
                    issue_bin  = '0;
                    rd_bank_d  = fq_q[0];
                    rd_bin_d   = LGNB'(1);
                    rd_state_d = RdStream;
                end
            end
            RdStream: begin
                if (space) begin
                    rd_issue = 1'b1;
                    rd_bin_d = rd_bin_q + 1'b1;
                    if (rd_bin_q == LastBin) rd_state_d = RdIdle;
                end
            end
            default: rd_state_d = RdIdle;
        endcase
        issue_last = (issue_bin == LastBin);
    end

    // Output buffer: pop on handshake, fill from RAM at the slot after the live entries
    always_comb begin
        fo_pwr_d  = fo_pwr_q;
        fo_bin_d  = fo_bin_q;
        fo_last_d = fo_last_q;
        fo_bank_d = fo_bank_q;
        fo_head_d = fo_head_q ^ pop_out;
        fo_wr_idx = fo_head_q ^ fo_cnt_q[0];
        fo_cnt_d  = fo_cnt_q + {1'b0, rd_issue} - {1'b0, pop_out};
        if (rd_issue) begin
            fo_pwr_d[fo_wr_idx]  = mem[{issue_bank, issue_bin}];
            fo_bin_d[fo_wr_idx]  = issue_bin;
            fo_last_d[fo_wr_idx] = issue_last;
            fo_bank_d[fo_wr_idx] = issue_bank;
        end
        // Set wins over a simultaneous clear.
        ov_d = (ov_q && !i_clr_overflow) || ov_set;
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_state_q <= WrWaitSync;
            wr_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            bank_st_q  <= {BankEmpty, BankEmpty};
            s1_vld_q   <= 1'b0;
            s1_bank_q  <= 1'b0;
            s1_bin_q   <= '0;
            s1_last_q  <= 1'b0;
            s1_re2_q   <= '0;
            s1_im2_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_bank_q  <= 1'b0;
            s2_bin_q   <= '0;
            s2_last_q  <= 1'b0;
            s2_pwr_q   <= '0;
            fq_q       <= '0;
            fq_cnt_q   <= '0;
            rd_state_q <= RdIdle;
            rd_bank_q  <= 1'b0;
            rd_bin_q   <= '0;
            fo_pwr_q   <= '0;
            fo_bin_q   <= '0;
            fo_last_q  <= '0;
            fo_bank_q  <= '0;
            fo_head_q  <= 1'b0;
            fo_cnt_q   <= '0;
            ov_q       <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_bank_q  <= wr_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            bank_st_q  <= bank_st_d;
            s1_vld_q   <= in_wr;
            s1_bank_q  <= wr_bank_d;
            s1_bin_q   <= in_bin;
            s1_last_q  <= in_last;
            s1_re2_q   <= re_sq;
            s1_im2_q   <= im_sq;
            s2_vld_q   <= s1_vld_q;
            s2_bank_q  <= s1_bank_q;
            s2_bin_q   <= s1_bin_q;
            s2_last_q  <= s1_last_q;
            s2_pwr_q   <= s1_re2_q + s1_im2_q;
            fq_q       <= fq_d;
            fq_cnt_q   <= fq_cnt_d;
            rd_state_q <= rd_state_d;
            rd_bank_q  <= rd_bank_d;
            rd_bin_q   <= rd_bin_d;
            fo_pwr_q   <= fo_pwr_d;
            fo_bin_q   <= fo_bin_d;
            fo_last_q  <= fo_last_d;
            fo_bank_q  <= fo_bank_d;
            fo_head_q  <= fo_head_d;
            fo_cnt_q   <= fo_cnt_d;
            ov_q       <= ov_d;
        end
    end

    // Two-bank power RAM, addressed {bank, bin}; contents need no reset
    always_ff @(posedge i_clk) begin
        if (s2_vld_q) mem[{s2_bank_q, s2_bin_q}] <= s2_pwr_q;
    end

endmodule
